// File: rtl/fetch_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue_if
// Purpose  : Bundles the instruction-memory request/response signals and the
//            decode-side valid/ready signals used by fetch_queue.
// Ports    : master - fetch side (drives imem_req/imem_addr and id_*)
//            slave  - memory/decode side (drives imem_rdata and id_ready)
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_queue_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [31:0]     id_instr;
  logic            id_ready;

  modport master (
    output imem_req, imem_addr, id_valid, id_pc, id_instr,
    input  imem_rdata, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, id_valid, id_pc, id_instr,
    output imem_rdata, id_ready
  );
endinterface
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Purpose  : Instruction fetch front end. Issues sequential word fetches while
//            id_en is high, buffers (pc, instr) pairs in a small FIFO and
//            hands them to decode over valid/ready. flush redirects the PC and
//            discards queued and in-flight work.
// Ports    : clk, rst (async, active high), id_en, flush, flush_pc,
//            bus (fetch_queue_if.master: imem_* and id_*), count (occupancy)
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] PC_RESET = 32'h0000_0000
) (
  input  wire logic                     clk,
  input  wire logic                     rst,
  input  wire logic                     id_en,
  input  wire logic                     flush,
  input  wire logic [XLEN-1:0]          flush_pc,
  fetch_queue_if.master                 bus,
  output logic [$clog2(DEPTH):0]        count
);

  localparam int              c_PW    = $clog2(DEPTH);
  localparam logic [c_PW:0]   c_DEPTH = (c_PW+1)'(DEPTH);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_req_pc;
  logic            r_inflight;
  logic [c_PW-1:0] r_head;
  logic [c_PW-1:0] r_tail;
  logic [c_PW:0]   r_count;
  logic [XLEN-1:0] r_mem_pc    [DEPTH];
  logic [31:0]     r_mem_instr [DEPTH];

  logic [c_PW:0]   w_occ;
  logic            w_req;
  logic            w_push;
  logic            w_pop;
  logic            w_valid;

  // Credit check: an in-flight response already owns a slot, so it is
  // counted against capacity before the next request is allowed out.
  assign w_occ   = r_count + (c_PW+1)'(r_inflight);
  assign w_req   = id_en & ~flush & ~rst & (w_occ < c_DEPTH);
  assign w_valid = (r_count != '0);
  // A response landing in the flush cycle belongs to the old path.
  assign w_push  = r_inflight & ~flush;
  assign w_pop   = w_valid & bus.id_ready & ~flush;

  assign bus.imem_req  = w_req;
  assign bus.imem_addr = r_pc;
  assign bus.id_valid  = w_valid;
  assign bus.id_pc     = w_valid ? r_mem_pc[r_head]    : '0;
  assign bus.id_instr  = w_valid ? r_mem_instr[r_head] : '0;
  assign count         = r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc       <= PC_RESET;
      r_req_pc   <= '0;
      r_inflight <= 1'b0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
    end else if (flush) begin
      r_pc       <= {flush_pc[XLEN-1:2], 2'b00};
      r_inflight <= 1'b0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
    end else begin
      r_inflight <= w_req;
      if (w_req) begin
        r_pc     <= r_pc + XLEN'(4);
        r_req_pc <= r_pc;
      end
      if (w_push) r_tail <= r_tail + c_PW'(1);
      if (w_pop)  r_head <= r_head + c_PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (c_PW+1)'(1);
        2'b01:   r_count <= r_count - (c_PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; occupancy alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_pc[r_tail]    <= r_req_pc;
      r_mem_instr[r_tail] <= bus.imem_rdata;
    end
  end

endmodule
`default_nettype wire
